// File: rtl/mmu_req_arbiter.sv
// mmu_req_arbiter
//   Shares the MMU alloc/free request FIFOs between NUM_REQ client engines
//   with round-robin arbitration. It tags every request ID with the client
//   index, pops the MMU alloc/free response FIFOs, and routes each response
//   back to the client that issued the request. It also limits the number of
//   requests each client may have outstanding.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_*                          per-client request channel (packed per client)
//   req_ready                      one-hot or zero grant, combinational
//   alloc_req_* / free_req_*       push side of the MMU request FIFOs
//   alloc_rsp_* / free_rsp_*       pop side of the MMU response FIFOs
//                                  (read data is valid the cycle after a pop)
//   rsp_*                          registered response to the clients;
//                                  rsp_valid is a one-cycle one-hot strobe
//   protocol_err                   sticky: a response arrived for a client
//                                  that had nothing outstanding
module mmu_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int SEL_W          = 2,
  parameter int ID_WIDTH       = 8,
  parameter int TAG_W          = 6,
  parameter int PAGE_IDX_WIDTH = 15,
  parameter int SIZE_WIDTH     = 4,
  parameter int FAIL_W         = 2,
  parameter int MAX_OUT        = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0]                 req_is_free,
  input  logic [NUM_REQ*TAG_W-1:0]           req_tag,
  input  logic [NUM_REQ*PAGE_IDX_WIDTH-1:0]  req_page_idx,
  input  logic [NUM_REQ*SIZE_WIDTH-1:0]      req_page_count,
  output logic                               alloc_req_wr_en,
  output logic [ID_WIDTH-1:0]                alloc_req_id,
  output logic [SIZE_WIDTH-1:0]              alloc_req_page_count,
  input  logic                               alloc_req_full,
  output logic                               free_req_wr_en,
  output logic [ID_WIDTH-1:0]                free_req_id,
  output logic [PAGE_IDX_WIDTH-1:0]          free_req_page_idx,
  output logic [SIZE_WIDTH-1:0]              free_req_page_count,
  input  logic                               free_req_full,
  input  logic                               alloc_rsp_empty,
  output logic                               alloc_rsp_pop,
  input  logic [ID_WIDTH-1:0]                alloc_rsp_id,
  input  logic [PAGE_IDX_WIDTH-1:0]          alloc_rsp_page_idx,
  input  logic                               alloc_rsp_fail,
  input  logic [FAIL_W-1:0]                  alloc_rsp_fail_reason,
  input  logic                               free_rsp_empty,
  output logic                               free_rsp_pop,
  input  logic [ID_WIDTH-1:0]                free_rsp_id,
  input  logic                               free_rsp_fail,
  input  logic [FAIL_W-1:0]                  free_rsp_fail_reason,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic                               rsp_is_free,
  output logic [TAG_W-1:0]                   rsp_tag,
  output logic [PAGE_IDX_WIDTH-1:0]          rsp_page_idx,
  output logic                               rsp_fail,
  output logic [FAIL_W-1:0]                  rsp_fail_reason,
  output logic                               protocol_err
);

  localparam int CNT_W = 4;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ALLOC = 2'd1,
    R_FREE  = 2'd2
  } rsp_state_e;

  // State
  logic [SEL_W-1:0]              rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
  rsp_state_e                    state_q, state_d;
  logic                          last_was_free_q;
  logic                          protocol_err_q, protocol_err_d;
  logic [NUM_REQ-1:0]            rsp_valid_q;
  logic                          rsp_is_free_q;
  logic [TAG_W-1:0]              rsp_tag_q;
  logic [PAGE_IDX_WIDTH-1:0]     rsp_page_idx_q;
  logic                          rsp_fail_q;
  logic [FAIL_W-1:0]             rsp_fail_reason_q;

  // Arbitration
  logic [NUM_REQ-1:0] eligible;
  logic               gnt_vld;
  logic [SEL_W-1:0]   gnt_idx;
  logic [SEL_W-1:0]   cand;
  logic [TAG_W-1:0]   gnt_tag;

  // Response capture (valid while the FSM sits in R_ALLOC / R_FREE)
  logic                      cap_vld;
  logic                      cap_free;
  logic [ID_WIDTH-1:0]       cap_id;
  logic [PAGE_IDX_WIDTH-1:0] cap_page;
  logic                      cap_fail;
  logic [FAIL_W-1:0]         cap_reason;
  logic [SEL_W-1:0]          cap_sel;
  logic [NUM_REQ-1:0]        deliver;

  // A client is eligible only if its own target FIFO has room, so a full
  // FIFO never blocks clients heading for the other one.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUT)) &&
                    !(req_is_free[i] ? free_req_full : alloc_req_full);
    end
  end

  // Round-robin search starting at rr_ptr; the SEL_W-bit add wraps modulo
  // NUM_REQ because NUM_REQ is a power of two.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = rr_ptr_q;
    cand    = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_ptr_q + SEL_W'(k);
      if (!gnt_vld && eligible[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign req_ready = gnt_vld ? (ONE_HOT0 << gnt_idx) : '0;
  assign rr_ptr_d  = gnt_vld ? gnt_idx + SEL_W'(1) : rr_ptr_q;
  assign gnt_tag   = req_tag[gnt_idx*TAG_W +: TAG_W];

  assign alloc_req_wr_en      = gnt_vld && !req_is_free[gnt_idx];
  assign alloc_req_id         = {gnt_idx, gnt_tag};
  assign alloc_req_page_count = req_page_count[gnt_idx*SIZE_WIDTH +: SIZE_WIDTH];
  assign free_req_wr_en       = gnt_vld && req_is_free[gnt_idx];
  assign free_req_id          = {gnt_idx, gnt_tag};
  assign free_req_page_idx    = req_page_idx[gnt_idx*PAGE_IDX_WIDTH +: PAGE_IDX_WIDTH];
  assign free_req_page_count  = req_page_count[gnt_idx*SIZE_WIDTH +: SIZE_WIDTH];

  // Response FSM: pop in R_IDLE, capture read data in R_ALLOC/R_FREE.
  // When both FIFOs have data, last_was_free makes them alternate.
  always_comb begin
    state_d       = state_q;
    alloc_rsp_pop = 1'b0;
    free_rsp_pop  = 1'b0;
    cap_vld       = 1'b0;
    cap_free      = 1'b0;
    cap_id        = alloc_rsp_id;
    cap_page      = alloc_rsp_page_idx;
    cap_fail      = alloc_rsp_fail;
    cap_reason    = alloc_rsp_fail_reason;
    case (state_q)
      R_IDLE: begin
        if (!alloc_rsp_empty && (last_was_free_q || free_rsp_empty)) begin
          alloc_rsp_pop = 1'b1;
          state_d       = R_ALLOC;
        end else if (!free_rsp_empty) begin
          free_rsp_pop = 1'b1;
          state_d      = R_FREE;
        end
      end
      R_ALLOC: begin
        cap_vld = 1'b1;
        state_d = R_IDLE;
      end
      R_FREE: begin
        cap_vld    = 1'b1;
        cap_free   = 1'b1;
        cap_id     = free_rsp_id;
        cap_page   = '0;
        cap_fail   = free_rsp_fail;
        cap_reason = free_rsp_fail_reason;
        state_d    = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign cap_sel = cap_id[ID_WIDTH-1 -: SEL_W];
  assign deliver = cap_vld ? (ONE_HOT0 << cap_sel) : '0;

  // Outstanding counters. A delivery to an idle client is a protocol error;
  // the counter saturates at 0 and the response still goes out.
  always_comb begin
    cnt_d          = cnt_q;
    protocol_err_d = protocol_err_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i] && req_valid[i] && !deliver[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (deliver[i] && !(req_ready[i] && req_valid[i]) && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      if (deliver[i] && (cnt_q[i] == '0)) begin
        protocol_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q          <= '0;
      cnt_q             <= '0;
      state_q           <= R_IDLE;
      // Alloc responses win the first tie after reset.
      last_was_free_q   <= 1'b1;
      protocol_err_q    <= 1'b0;
      rsp_valid_q       <= '0;
      rsp_is_free_q     <= 1'b0;
      rsp_tag_q         <= '0;
      rsp_page_idx_q    <= '0;
      rsp_fail_q        <= 1'b0;
      rsp_fail_reason_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      protocol_err_q <= protocol_err_d;
      rsp_valid_q    <= deliver;
      if (cap_vld) begin
        last_was_free_q   <= cap_free;
        rsp_is_free_q     <= cap_free;
        rsp_tag_q         <= cap_id[TAG_W-1:0];
        rsp_page_idx_q    <= cap_page;
        rsp_fail_q        <= cap_fail;
        rsp_fail_reason_q <= cap_reason;
      end
    end
  end

  assign rsp_valid       = rsp_valid_q;
  assign rsp_is_free     = rsp_is_free_q;
  assign rsp_tag         = rsp_tag_q;
  assign rsp_page_idx    = rsp_page_idx_q;
  assign rsp_fail        = rsp_fail_q;
  assign rsp_fail_reason = rsp_fail_reason_q;
  assign protocol_err    = protocol_err_q;

endmodule
